// File: rtl/codec_sample_stage_if.sv
// Sample-path bundle between the music player, the codec output stage and the codec.
// The master side feeds samples and frame strobes; the slave side is the output stage.
interface codec_sample_stage_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic signed [15:0]            sample_in;
    logic                          sample_valid;
    logic                          new_frame;
    logic [1:0]                    aural_state;
    logic                          clear_stats;
    logic signed [15:0]            pcm_left;
    logic signed [15:0]            pcm_right;
    logic [$clog2(FIFO_DEPTH):0]   fill_level;
    logic [CNT_WIDTH-1:0]          underrun_cnt;
    logic [CNT_WIDTH-1:0]          overflow_cnt;

    modport master (
        output sample_in, sample_valid, new_frame, aural_state, clear_stats,
        input  pcm_left, pcm_right, fill_level, underrun_cnt, overflow_cnt
    );

    modport slave (
        input  sample_in, sample_valid, new_frame, aural_state, clear_stats,
        output pcm_left, pcm_right, fill_level, underrun_cnt, overflow_cnt
    );
endinterface

// File: rtl/codec_sample_stage.sv
// Elastic codec output stage: sample FIFO popped once per codec frame, with per-channel
// gain ramps so channel mute/unmute follows a click-free slope.
module codec_sample_stage #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAIN_BITS  = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    codec_sample_stage_if.slave  bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int GW     = GAIN_BITS + 1;
    localparam int PROD_W = 16 + GW + 1;
    localparam logic [GW-1:0] GAIN_MAX = {1'b1, {GAIN_BITS{1'b0}}};

    logic signed [15:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [FILL_W-1:0]    fill;
    logic signed [15:0]   held;
    logic [GW-1:0]        gain_l;
    logic [GW-1:0]        gain_r;
    logic                 frame_d;
    logic signed [15:0]   pcm_l;
    logic signed [15:0]   pcm_r;
    logic [CNT_WIDTH-1:0] underrun;
    logic [CNT_WIDTH-1:0] overflow;

    logic full;
    logic empty;
    logic do_pop;
    logic do_push;
    logic drop;
    logic under;

    // A pop on a full FIFO frees a slot, so a simultaneous push is still accepted.
    assign full    = (fill == FILL_W'(FIFO_DEPTH));
    assign empty   = (fill == '0);
    assign do_pop  = bus.new_frame && !empty;
    assign under   = bus.new_frame && empty;
    assign do_push = bus.sample_valid && (!full || do_pop);
    assign drop    = bus.sample_valid && full && !do_pop;

    function automatic logic [GW-1:0] step_gain(input logic [GW-1:0] g, input logic en);
        logic [GW-1:0] tgt;
        tgt = en ? GAIN_MAX : '0;
        if (g < tgt)
            return g + GW'(1);
        else if (g > tgt)
            return g - GW'(1);
        else
            return g;
    endfunction

    // Gain is treated as unsigned; unity gain gives an exact passthrough after the shift.
    function automatic logic signed [15:0] scale(input logic signed [15:0] s,
                                                 input logic [GW-1:0] g);
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(s) * PROD_W'($signed({1'b0, g}));
        p = p >>> GAIN_BITS;
        return p[15:0];
    endfunction

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= bus.sample_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            held     <= '0;
            gain_l   <= '0;
            gain_r   <= '0;
            frame_d  <= 1'b0;
            pcm_l    <= '0;
            pcm_r    <= '0;
            underrun <= '0;
            overflow <= '0;
        end else begin
            frame_d <= bus.new_frame;
            fill    <= fill + FILL_W'(do_push) - FILL_W'(do_pop);
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                held   <= mem[rd_ptr];
            end
            if (bus.new_frame) begin
                gain_l <= step_gain(gain_l, bus.aural_state[0]);
                gain_r <= step_gain(gain_r, bus.aural_state[1]);
            end
            if (frame_d) begin
                pcm_l <= scale(held, gain_l);
                pcm_r <= scale(held, gain_r);
            end
            // Counters saturate; a clear in the same cycle overrides any increment.
            if (bus.clear_stats) begin
                underrun <= '0;
                overflow <= '0;
            end else begin
                if (under && underrun != '1)
                    underrun <= underrun + CNT_WIDTH'(1);
                if (drop && overflow != '1)
                    overflow <= overflow + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.pcm_left     = pcm_l;
    assign bus.pcm_right    = pcm_r;
    assign bus.fill_level   = fill;
    assign bus.underrun_cnt = underrun;
    assign bus.overflow_cnt = overflow;
endmodule

// File: tb/tb_codec_sample_stage.sv
// Bench for codec_sample_stage: directed pushes/frames with hand-computed PCM words
// queued per frame and checked by an independent monitor one cycle after each frame.
module tb_codec_sample_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    codec_sample_stage_if #(.FIFO_DEPTH(8), .CNT_WIDTH(8)) bus ();

    codec_sample_stage #(
        .FIFO_DEPTH(8),
        .GAIN_BITS (4),
        .CNT_WIDTH (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    logic signed [15:0] exp_l_q[$];
    logic signed [15:0] exp_r_q[$];
    logic pend1;
    logic pend2;

    task automatic check_output(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Tracks frames so the monitor looks at the PCM words the cycle after each pop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend1 <= 1'b0;
            pend2 <= 1'b0;
        end else begin
            pend1 <= bus.new_frame;
            pend2 <= pend1;
        end
    end

    always @(negedge clk) begin
        if (pend2) begin
            if (exp_l_q.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL pcm_unexpected: got output %0d/%0d, expected none",
                         bus.pcm_left, bus.pcm_right);
            end else begin
                check_output("pcm_left", bus.pcm_left, exp_l_q.pop_front());
                check_output("pcm_right", bus.pcm_right, exp_r_q.pop_front());
            end
        end
    end

    task automatic apply_stimulus(input logic push, input int data, input logic frame,
                                  input logic clr);
        bus.sample_valid = push;
        bus.sample_in    = 16'(data);
        bus.new_frame    = frame;
        bus.clear_stats  = clr;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.new_frame    = 1'b0;
        bus.clear_stats  = 1'b0;
    endtask

    task automatic push_word(input int data);
        apply_stimulus(1'b1, data, 1'b0, 1'b0);
    endtask

    task automatic frame_expect(input int el, input int er);
        exp_l_q.push_back(16'(el));
        exp_r_q.push_back(16'(er));
        apply_stimulus(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic push_frame_expect(input int data, input int el, input int er);
        exp_l_q.push_back(16'(el));
        exp_r_q.push_back(16'(er));
        apply_stimulus(1'b1, data, 1'b1, 1'b0);
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ramp[17];
        ramp = '{6, 25, 37, 50, 62, 75, 87, 100, 112, 125, 137, 150, 162, 175, 187, 200, 200};

        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.new_frame    = 1'b0;
        bus.aural_state  = 2'b11;
        bus.clear_stats  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_pcm_left", bus.pcm_left, 0);
        check_output("reset_pcm_right", bus.pcm_right, 0);
        check_output("reset_fill", int'(bus.fill_level), 0);
        check_output("reset_underrun", int'(bus.underrun_cnt), 0);
        check_output("reset_overflow", int'(bus.overflow_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] ramp up from reset");
        push_word(100);
        push_word(200);
        check_output("ramp_fill_before", int'(bus.fill_level), 2);
        for (int i = 0; i < 17; i++)
            frame_expect(ramp[i], ramp[i]);
        drain();
        check_output("ramp_fill_after", int'(bus.fill_level), 0);
        check_output("ramp_underrun", int'(bus.underrun_cnt), 15);

        $display("[TB] unity gain extremes");
        push_word(-32768);
        push_word(0);
        push_word(32767);
        frame_expect(-32768, -32768);
        frame_expect(0, 0);
        frame_expect(32767, 32767);
        drain();

        $display("[TB] underrun repeat and clear");
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        check_output("clear_underrun", int'(bus.underrun_cnt), 0);
        for (int i = 0; i < 3; i++)
            frame_expect(32767, 32767);
        check_output("underrun_three", int'(bus.underrun_cnt), 3);
        exp_l_q.push_back(16'sd32767);
        exp_r_q.push_back(16'sd32767);
        apply_stimulus(1'b0, 0, 1'b1, 1'b1);
        check_output("clear_wins", int'(bus.underrun_cnt), 0);
        drain();

        $display("[TB] overflow and ordering");
        for (int i = 1; i <= 10; i++)
            push_word(1000 * i);
        check_output("overflow_fill", int'(bus.fill_level), 8);
        check_output("overflow_cnt", int'(bus.overflow_cnt), 2);
        for (int i = 1; i <= 8; i++)
            frame_expect(1000 * i, 1000 * i);
        drain();
        check_output("overflow_drain_fill", int'(bus.fill_level), 0);
        check_output("overflow_no_underrun", int'(bus.underrun_cnt), 0);

        $display("[TB] simultaneous push and pop");
        for (int i = 1; i <= 8; i++)
            push_word(3000 + 100 * i);
        check_output("full_fill", int'(bus.fill_level), 8);
        push_frame_expect(3900, 3100, 3100);
        check_output("full_pushpop_fill", int'(bus.fill_level), 8);
        check_output("full_pushpop_overflow", int'(bus.overflow_cnt), 2);
        for (int i = 2; i <= 9; i++)
            frame_expect(3000 + 100 * i, 3000 + 100 * i);
        drain();
        check_output("full_drain_fill", int'(bus.fill_level), 0);
        push_frame_expect(4000, 3900, 3900);
        check_output("empty_pushpop_underrun", int'(bus.underrun_cnt), 1);
        check_output("empty_pushpop_fill", int'(bus.fill_level), 1);
        frame_expect(4000, 4000);
        drain();
        check_output("empty_pushpop_drain", int'(bus.fill_level), 0);

        $display("[TB] channel mute ramps");
        push_word(1600);
        frame_expect(1600, 1600);
        bus.aural_state = 2'b01;
        for (int k = 1; k <= 8; k++)
            frame_expect(1600, 1600 - 100 * k);
        bus.aural_state = 2'b11;
        for (int k = 1; k <= 8; k++)
            frame_expect(1600, 800 + 100 * k);
        bus.aural_state = 2'b01;
        for (int k = 1; k <= 16; k++)
            frame_expect(1600, 1600 - 100 * k);
        frame_expect(1600, 0);
        bus.aural_state = 2'b11;
        for (int k = 1; k <= 4; k++)
            frame_expect(1600, 100 * k);
        drain();

        $display("[TB] reset mid-ramp");
        push_word(555);
        check_output("pre_reset_fill", int'(bus.fill_level), 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("midreset_pcm_left", bus.pcm_left, 0);
        check_output("midreset_pcm_right", bus.pcm_right, 0);
        check_output("midreset_fill", int'(bus.fill_level), 0);
        check_output("midreset_underrun", int'(bus.underrun_cnt), 0);
        check_output("midreset_overflow", int'(bus.overflow_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_word(160);
        frame_expect(10, 10);
        drain();

        for (int i = 0; i < 20 && exp_l_q.size() != 0; i++)
            @(negedge clk);
        if (exp_l_q.size() != 0) begin
            total_cnt++;
            $display("[TB] FAIL pcm_missing: got %0d outstanding frames, expected 0",
                     exp_l_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
